// File: rtl/pc_stall_ctrl_if.sv
// PC stall controller handshake bundle.
// Pipeline requests flow in; stall, flush and status flow out.
interface pc_stall_ctrl_if;
    logic        isDiv;
    logic        divDone;
    logic        redirect;
    logic        divIsActive;
    logic        divStart;
    logic        flush;
    logic        divErr;
    logic [15:0] stallCount;

    modport master (
        output isDiv,
        output divDone,
        output redirect,
        input  divIsActive,
        input  divStart,
        input  flush,
        input  divErr,
        input  stallCount
    );

    modport slave (
        input  isDiv,
        input  divDone,
        input  redirect,
        output divIsActive,
        output divStart,
        output flush,
        output divErr,
        output stallCount
    );
endinterface

// File: rtl/pc_stall_ctrl.sv
// PC hold / squash controller for multi-cycle divide and redirects.
// All outputs are registered from the next-state decode.
module pc_stall_ctrl #(
    parameter int FLUSH_DEPTH = 4,
    parameter int DIV_TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           resetN,
    pc_stall_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [5:0] BUSY_LAST  = 6'(DIV_TIMEOUT - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

    state_t     state;
    state_t     state_nxt;
    logic [5:0] busyCnt;
    logic [5:0] busy_nxt;
    logic [3:0] flushCnt;
    logic [3:0] flush_nxt;
    logic       err_nxt;

    always_comb begin
        state_nxt = state;
        busy_nxt  = busyCnt;
        flush_nxt = flushCnt;
        err_nxt   = bus.divErr;
        unique case (state)
            IDLE: begin
                // redirect beats a simultaneous divide
                if (bus.redirect) begin
                    state_nxt = FLUSH;
                    flush_nxt = FLUSH_LOAD;
                end else if (bus.isDiv) begin
                    state_nxt = BUSY;
                    busy_nxt  = 6'd0;
                end
            end
            BUSY: begin
                busy_nxt = busyCnt + 6'd1;
                if (bus.divDone) begin
                    state_nxt = IDLE;
                end else if (busyCnt == BUSY_LAST) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.redirect) begin
                    flush_nxt = FLUSH_LOAD;
                end else if (flushCnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    flush_nxt = flushCnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state           <= IDLE;
            busyCnt         <= 6'd0;
            flushCnt        <= 4'd0;
            bus.divIsActive <= 1'b0;
            bus.divStart    <= 1'b0;
            bus.flush       <= 1'b0;
            bus.divErr      <= 1'b0;
            bus.stallCount  <= 16'd0;
        end else begin
            state           <= state_nxt;
            busyCnt         <= busy_nxt;
            flushCnt        <= flush_nxt;
            bus.divIsActive <= (state_nxt == BUSY);
            bus.divStart    <= (state == IDLE) && (state_nxt == BUSY);
            bus.flush       <= (state_nxt == FLUSH);
            bus.divErr      <= err_nxt;
            if (bus.divIsActive && (bus.stallCount != 16'hFFFF)) begin
                bus.stallCount <= bus.stallCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_stall_ctrl.sv
// Directed bench for pc_stall_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_pc_stall_ctrl;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    pc_stall_ctrl_if u_if ();

    pc_stall_ctrl #(
        .FLUSH_DEPTH(4),
        .DIV_TIMEOUT(32)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (u_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        u_if.isDiv    = 1'b0;
        u_if.divDone  = 1'b0;
        u_if.redirect = 1'b0;

        // reset state
        #7;
        chk("rst_active", 32'(u_if.divIsActive), 0);
        chk("rst_start", 32'(u_if.divStart), 0);
        chk("rst_flush", 32'(u_if.flush), 0);
        chk("rst_err", 32'(u_if.divErr), 0);
        chk("rst_cnt", 32'(u_if.stallCount), 0);
        #1 resetN = 1'b1;
        tick();

        // divide, done after 6 busy cycles
        u_if.isDiv = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            u_if.isDiv = 1'b0;
            chk($sformatf("div_act%0d", k), 32'(u_if.divIsActive), 1);
            chk($sformatf("div_start%0d", k), 32'(u_if.divStart),
                (k == 1) ? 32'd1 : 32'd0);
            u_if.divDone = (k == 6);
        end
        tick();
        u_if.divDone = 1'b0;
        chk("div_end_act", 32'(u_if.divIsActive), 0);
        chk("div_end_cnt", 32'(u_if.stallCount), 6);
        chk("div_end_err", 32'(u_if.divErr), 0);
        tick();

        // divDone coincides with the timeout cycle
        u_if.isDiv = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            u_if.isDiv = 1'b0;
            if (k == 1 || k == 32)
                chk($sformatf("co_act%0d", k), 32'(u_if.divIsActive), 1);
            u_if.divDone = (k == 32);
        end
        tick();
        u_if.divDone = 1'b0;
        chk("co_act_end", 32'(u_if.divIsActive), 0);
        chk("co_err", 32'(u_if.divErr), 0);
        chk("co_cnt", 32'(u_if.stallCount), 38);
        tick();

        // timeout with no divDone
        u_if.isDiv = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            u_if.isDiv = 1'b0;
            if (k == 1 || k == 31 || k == 32) begin
                chk($sformatf("to_act%0d", k), 32'(u_if.divIsActive), 1);
                chk($sformatf("to_err%0d", k), 32'(u_if.divErr), 0);
            end
        end
        tick();
        chk("to_act_end", 32'(u_if.divIsActive), 0);
        chk("to_err_set", 32'(u_if.divErr), 1);
        chk("to_cnt", 32'(u_if.stallCount), 70);

        // stray divDone in IDLE
        u_if.divDone = 1'b1;
        tick();
        u_if.divDone = 1'b0;
        chk("idle_done_act", 32'(u_if.divIsActive), 0);
        chk("idle_done_flush", 32'(u_if.flush), 0);
        chk("idle_done_cnt", 32'(u_if.stallCount), 70);

        // redirect, re-redirect, squashed divide
        u_if.redirect = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            u_if.redirect = (k == 2);
            u_if.isDiv    = (k == 3);
            chk($sformatf("rd_flush%0d", k), 32'(u_if.flush),
                (k <= 6) ? 32'd1 : 32'd0);
            chk($sformatf("rd_start%0d", k), 32'(u_if.divStart), 0);
            chk($sformatf("rd_act%0d", k), 32'(u_if.divIsActive), 0);
        end
        chk("rd_err_held", 32'(u_if.divErr), 1);
        tick();

        // simultaneous isDiv and redirect
        u_if.isDiv    = 1'b1;
        u_if.redirect = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            u_if.isDiv    = 1'b0;
            u_if.redirect = 1'b0;
            chk($sformatf("sim_flush%0d", k), 32'(u_if.flush),
                (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("sim_start%0d", k), 32'(u_if.divStart), 0);
            chk($sformatf("sim_act%0d", k), 32'(u_if.divIsActive), 0);
        end

        // async reset at BUSY cycle 3
        u_if.isDiv = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            u_if.isDiv = 1'b0;
        end
        chk("ar_act_before", 32'(u_if.divIsActive), 1);
        #2 resetN = 1'b0;
        #1;
        chk("ar_act", 32'(u_if.divIsActive), 0);
        chk("ar_start", 32'(u_if.divStart), 0);
        chk("ar_cnt", 32'(u_if.stallCount), 0);
        chk("ar_err", 32'(u_if.divErr), 0);
        #2 resetN = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("ar_post_start%0d", k), 32'(u_if.divStart), 0);
            chk($sformatf("ar_post_act%0d", k), 32'(u_if.divIsActive), 0);
        end

        // saturation from a preloaded count
        #2 force u_if.stallCount = 16'hFFFC;
        #1 release u_if.stallCount;
        tick();
        u_if.isDiv = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            u_if.isDiv = 1'b0;
            if (k >= 4)
                chk($sformatf("sat_cnt%0d", k), 32'(u_if.stallCount),
                    32'h0000FFFF);
            u_if.divDone = (k == 5);
        end
        tick();
        u_if.divDone = 1'b0;
        chk("sat_cnt_end", 32'(u_if.stallCount), 32'h0000FFFF);
        chk("sat_act_end", 32'(u_if.divIsActive), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
